// File: rtl/branch_target_buffer_if.sv
// Fetch/decode-side signal bundle for branch_target_buffer.
// The testbench or pipeline drives through master; the BTB connects as slave.
interface branch_target_buffer_if;
  logic        STALL;
  logic [31:0] Instr_PC_IN_IF;
  logic [31:0] Instr_PC_IN_ID;
  logic        is_Branch_IN_ID;
  logic        is_Taken_IN_ID;
  logic [31:0] Alt_PC_IN_ID;
  logic        FLUSH;
  logic        take_Branch_OUT_IF;
  logic [31:0] take_Alt_PC_OUT_IF;

  modport master (
    output STALL, Instr_PC_IN_IF, Instr_PC_IN_ID, is_Branch_IN_ID,
           is_Taken_IN_ID, Alt_PC_IN_ID,
    input  FLUSH, take_Branch_OUT_IF, take_Alt_PC_OUT_IF
  );

  modport slave (
    input  STALL, Instr_PC_IN_IF, Instr_PC_IN_ID, is_Branch_IN_ID,
           is_Taken_IN_ID, Alt_PC_IN_ID,
    output FLUSH, take_Branch_OUT_IF, take_Alt_PC_OUT_IF
  );
endinterface

// File: rtl/branch_target_buffer.sv
// Direct-mapped BTB with per-entry direction predictor and in-flight prediction queue.
// Define BTB_TWO_BIT_EN for 2-bit saturating counters; otherwise a 1-bit last-outcome predictor.
module branch_target_buffer #(
  parameter int INDEX_BITS      = 4,
  parameter int PIPE_DEPTH      = 8,
  parameter int FALLTHRU_OFFSET = 8
) (
  input  logic                   CLK,
  input  logic                   RESET,
  branch_target_buffer_if.slave  bus
);

  localparam int unsigned ENTRIES = 1 << INDEX_BITS;
  localparam int unsigned DEPTH   = PIPE_DEPTH;
  localparam int unsigned TAG_W   = 32 - INDEX_BITS - 2;

`ifdef BTB_TWO_BIT_EN
  localparam logic [1:0] CTR_RESET = 2'b01;
`else
  localparam logic [1:0] CTR_RESET = 2'b00;
`endif

  function automatic logic [1:0] ctr_next(input logic [1:0] ctr, input logic taken);
`ifdef BTB_TWO_BIT_EN
    if (taken) ctr_next = (ctr == 2'b11) ? 2'b11 : ctr + 2'b01;
    else       ctr_next = (ctr == 2'b00) ? 2'b00 : ctr - 2'b01;
`else
    // ctr[0] is never set in this mode; carrying it keeps it at zero
    ctr_next = {taken, ctr[0]};
`endif
  endfunction

  logic             valid_q [ENTRIES];
  logic [TAG_W-1:0] tag_q   [ENTRIES];
  logic [31:0]      tgt_q   [ENTRIES];
  logic [1:0]       ctr_q   [ENTRIES];

  logic [DEPTH-1:0] qvalid_q, qvalid_d;
  logic [DEPTH-1:0] qtaken_q, qtaken_d;
  logic [31:0]      qtgt_q [DEPTH];
  logic [31:0]      qtgt_d [DEPTH];

  logic [INDEX_BITS-1:0] if_idx, id_idx;
  logic [TAG_W-1:0]      if_tag, id_tag;
  logic                  if_hit, if_pred, id_hit;
  logic                  head_valid, head_pred;
  logic [31:0]           head_tgt;
  logic                  resolve, mispredict;
  logic [31:0]           corr_pc;
  logic                  unused_pc_lsbs;

  assign unused_pc_lsbs = ^{bus.Instr_PC_IN_IF[1:0], bus.Instr_PC_IN_ID[1:0]};

  assign if_idx  = bus.Instr_PC_IN_IF[INDEX_BITS+1:2];
  assign if_tag  = bus.Instr_PC_IN_IF[31:INDEX_BITS+2];
  assign id_idx  = bus.Instr_PC_IN_ID[INDEX_BITS+1:2];
  assign id_tag  = bus.Instr_PC_IN_ID[31:INDEX_BITS+2];
  assign if_hit  = valid_q[if_idx] && (tag_q[if_idx] == if_tag);
  assign if_pred = if_hit && ctr_q[if_idx][1];
  assign id_hit  = valid_q[id_idx] && (tag_q[id_idx] == id_tag);

  assign head_valid = qvalid_q[DEPTH-1];
  assign head_pred  = qtaken_q[DEPTH-1];
  assign head_tgt   = qtgt_q[DEPTH-1];
  assign resolve    = head_valid && !bus.STALL && !RESET;

  always_comb begin
    mispredict = 1'b0;
    corr_pc    = bus.Instr_PC_IN_ID + 32'd4;
    if (bus.is_Branch_IN_ID) begin
      if (bus.is_Taken_IN_ID) corr_pc = bus.Alt_PC_IN_ID;
      else                    corr_pc = bus.Instr_PC_IN_ID + 32'(FALLTHRU_OFFSET);
    end
    if (resolve) begin
      if (bus.is_Branch_IN_ID)
        mispredict = (bus.is_Taken_IN_ID != head_pred) ||
                     (bus.is_Taken_IN_ID && head_pred && (bus.Alt_PC_IN_ID != head_tgt));
      else
        mispredict = head_pred;
    end
  end

  // Redirect priority: reset silences everything, then mispredict, then IF prediction
  assign bus.FLUSH              = mispredict;
  assign bus.take_Branch_OUT_IF = !RESET && (mispredict || if_pred);
  always_comb begin
    bus.take_Alt_PC_OUT_IF = '0;
    if (!RESET) begin
      if (mispredict)  bus.take_Alt_PC_OUT_IF = corr_pc;
      else if (if_hit) bus.take_Alt_PC_OUT_IF = tgt_q[if_idx];
    end
  end

  always_comb begin
    qvalid_d = qvalid_q;
    qtaken_d = qtaken_q;
    qtgt_d   = qtgt_q;
    if (RESET) begin
      qvalid_d = '0;
    end else if (!bus.STALL) begin
      if (mispredict) begin
        qvalid_d = '0;
      end else begin
        for (int unsigned i = 1; i < DEPTH; i++) begin
          qvalid_d[i] = qvalid_q[i-1];
          qtaken_d[i] = qtaken_q[i-1];
          qtgt_d[i]   = qtgt_q[i-1];
        end
        qvalid_d[0] = 1'b1;
        qtaken_d[0] = if_pred;
        qtgt_d[0]   = tgt_q[if_idx];
      end
    end
  end

  always_ff @(posedge CLK) begin
    qvalid_q <= qvalid_d;
    qtaken_q <= qtaken_d;
    qtgt_q   <= qtgt_d;
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      for (int unsigned i = 0; i < ENTRIES; i++) begin
        valid_q[i] <= 1'b0;
        ctr_q[i]   <= CTR_RESET;
      end
    end else if (resolve) begin
      if (bus.is_Branch_IN_ID) begin
        if (id_hit) begin
          ctr_q[id_idx] <= ctr_next(ctr_q[id_idx], bus.is_Taken_IN_ID);
          if (bus.is_Taken_IN_ID) tgt_q[id_idx] <= bus.Alt_PC_IN_ID;
        end else if (bus.is_Taken_IN_ID) begin
          valid_q[id_idx] <= 1'b1;
          tag_q[id_idx]   <= id_tag;
          tgt_q[id_idx]   <= bus.Alt_PC_IN_ID;
          ctr_q[id_idx]   <= 2'b10;
        end
      end else if (id_hit && head_pred) begin
        valid_q[id_idx] <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_branch_target_buffer.sv
// Scoreboard bench for branch_target_buffer: directed fetch/resolve sequence.
module tb_branch_target_buffer;

  localparam logic [31:0] B     = 32'h0040_0020;
  localparam logic [31:0] T1    = 32'h0040_0100;
  localparam logic [31:0] T2    = 32'h0040_0200;
  localparam logic [31:0] T3    = 32'h0040_0300;
  localparam logic [31:0] FALL  = 32'h0040_0028;
  localparam logic [31:0] FILL  = 32'h0000_0000;
`ifdef BTB_TWO_BIT_EN
  localparam logic TWO = 1'b1;
`else
  localparam logic TWO = 1'b0;
`endif

  logic CLK = 1'b0;
  logic RESET;
  int   n_tests = 0;
  int   n_fail  = 0;

  typedef struct {
    string       tag;
    logic        fl;
    logic        tb;
    logic [31:0] pc;
    logic        chk_pc;
  } exp_t;
  exp_t sb[$];

  branch_target_buffer_if bus ();

  branch_target_buffer #(
    .INDEX_BITS(4),
    .PIPE_DEPTH(8),
    .FALLTHRU_OFFSET(8)
  ) dut (
    .CLK(CLK),
    .RESET(RESET),
    .bus(bus)
  );

  always #5 CLK = ~CLK;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  always @(negedge CLK) begin
    if (sb.size() != 0) begin
      exp_t e;
      e = sb.pop_front();
      check_eq({e.tag, "/flush"}, 32'(bus.FLUSH), 32'(e.fl));
      check_eq({e.tag, "/take"}, 32'(bus.take_Branch_OUT_IF), 32'(e.tb));
      if (e.chk_pc) check_eq({e.tag, "/alt_pc"}, bus.take_Alt_PC_OUT_IF, e.pc);
    end
  end

  task automatic cyc(input logic [31:0] ifpc, input logic br, input logic tk,
                     input logic [31:0] idpc, input logic [31:0] alt, input logic stall,
                     input logic efl, input logic etb, input logic [31:0] epc, input string tag);
    exp_t e;
    bus.Instr_PC_IN_IF  = ifpc;
    bus.is_Branch_IN_ID = br;
    bus.is_Taken_IN_ID  = tk;
    bus.Instr_PC_IN_ID  = idpc;
    bus.Alt_PC_IN_ID    = alt;
    bus.STALL           = stall;
    e.tag    = tag;
    e.fl     = efl;
    e.tb     = etb;
    e.pc     = epc;
    e.chk_pc = etb | RESET;
    sb.push_back(e);
    @(posedge CLK);
    #1;
  endtask

  task automatic fill(input int n, input string tag);
    for (int i = 0; i < n; i++) cyc(FILL, 1'b0, 1'b0, FILL, FILL, 1'b0, 1'b0, 1'b0, '0, tag);
  endtask

  task automatic fetch(input logic [31:0] pc, input logic etb, input logic [31:0] epc, input string tag);
    cyc(pc, 1'b0, 1'b0, FILL, FILL, 1'b0, 1'b0, etb, epc, tag);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    RESET = 1'b1;
    bus.STALL = 1'b0;
    bus.Instr_PC_IN_IF = '0;
    bus.Instr_PC_IN_ID = '0;
    bus.is_Branch_IN_ID = 1'b0;
    bus.is_Taken_IN_ID = 1'b0;
    bus.Alt_PC_IN_ID = '0;
    @(posedge CLK);
    #1;
    fill(2, "reset");
    RESET = 1'b0;

    fetch(32'h0040_0010, 1'b0, '0, "fetch10");
    fill(7, "bubble");

    // Cold miss on a taken branch
    fetch(B, 1'b0, '0, "cold_fetch");
    fill(7, "fill_a");
    cyc(FILL, 1'b1, 1'b1, B, T1, 1'b0, 1'b1, 1'b1, T1, "cold_resolve");

    fetch(B, 1'b1, T1, "hit_fetch");
    // Head is a bubble after the flush: a branch at ID must be ignored
    cyc(FILL, 1'b1, 1'b1, B, 32'h0040_0999, 1'b0, 1'b0, 1'b0, '0, "bubble_branch");
    fill(6, "fill_b");
    cyc(FILL, 1'b1, 1'b1, B, T1, 1'b0, 1'b0, 1'b0, '0, "taken_ok");

    fetch(B, 1'b1, T1, "fetch_again");
    fill(7, "fill_c");
    cyc(FILL, 1'b1, 1'b0, B, FILL, 1'b0, 1'b1, 1'b1, FALL, "not_taken");

    fetch(B, TWO, T1, "after_nt");
    fill(7, "fill_d");
    cyc(FILL, 1'b1, 1'b1, B, T2, 1'b0, 1'b1, 1'b1, T2, "new_target");

    fetch(B, 1'b1, T2, "fetch_t2");
    fill(7, "fill_e");
    for (int i = 0; i < 3; i++)
      cyc(FILL, 1'b1, 1'b0, B, FILL, 1'b1, 1'b0, 1'b0, '0, "stall");
    cyc(FILL, 1'b1, 1'b0, B, FILL, 1'b0, 1'b1, 1'b1, FALL, "unstall");

    fetch(B, TWO, T2, "fetch_pre_rst");
    fill(7, "fill_f");
    RESET = 1'b1;
    cyc(FILL, 1'b1, 1'b1, B, T3, 1'b0, 1'b0, 1'b0, '0, "rst_mispredict");
    RESET = 1'b0;
    fetch(B, 1'b0, '0, "post_rst_B");
    fetch(32'h0040_0010, 1'b0, '0, "post_rst_10");
    fill(8, "post_rst_fill");

    @(negedge CLK);
    check_eq("sb_drain", 32'(sb.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
